addsub4b: RTL and testbench
===========================

// Module: addsub4b
// PURPOSE
//   4-bit unsigned/two's-complement adder/subtractor with registered outputs.
//   - add_sub=0: R = A + B.
//   - add_sub=1: R = A - B.
//   - Co is the carry out of the bit-3 stage.
//   Datapath leaf block; operands and results are presented as individual bit ports.
// PARAMETERS
//   none (width fixed at 4 bits)
// PORTS
//   clk      in   1  rising-edge clock; the only clock
//   reset    in   1  synchronous, active-high reset
//   add_sub  in   1  operation select: 0 = add, 1 = subtract
//   A3..A0   in   1  operand A bits (A3 = MSB)
//   B3..B0   in   1  operand B bits (B3 = MSB)
//   Co       out  1  registered carry out of MSB stage (subtract: 1 = no borrow)
//   R3..R0   out  1  registered result bits (R3 = MSB)
// BEHAVIOUR
//   - Clocking and reset: one clock (clk). Reset is synchronous and active-high,
//     sampled on the rising edge of clk. While reset=1 at an edge: {Co,R3..R0} <= 5'b0.
//   - Reset has priority over the computed update.
//   - Datapath: ripple-carry chain of 4 one-bit full adders.
//     - Stage i inputs: Ai, (Bi XOR add_sub) and carry c_i.
//     - c_0 = add_sub. Subtract is A + ~B + 1.
//     - Stage i sum is Ai ^ Bx_i ^ c_i; carry out is majority(Ai, Bx_i, c_i).
//     - Co = c_4.
//   - Result width: {Co,R} = A + (B ^ {4{add_sub}}) + add_sub, truncated to 5 bits.
//   - Latency: exactly 1 cycle.
//     - Inputs are sampled at rising edge N.
//     - Outputs hold the result from edge N until edge N+1.
//     - Outputs never change between edges.
//   - No handshake: a new operation is accepted every cycle.
//   - Undefined (X/Z) inputs are not required to be handled. After reset, outputs
//     are always 0/1.
//   - Boundary conditions:
//     - Add overflow (A+B > 15): R wraps modulo 16 and Co=1.
//     - Subtract with A >= B: Co=1 and R = A-B.
//     - Subtract with A < B: Co=0 and R = (A-B) mod 16.
//     - A=B on subtract: R=0 and Co=1.
//     - add_sub toggling every cycle is fully supported; each cycle is independent.
//     - Reset asserted mid-stream clears the outputs at the next edge. The first
//       edge with reset=0 then registers that cycle's inputs.
//   - No overflow flag and no internal state beyond the 5 output flops.
// TESTING
//   - Reset: hold reset=1 for 2 edges with arbitrary inputs -> Co=0, R=0000.
//     Release reset -> the next edge registers the inputs.
//   - A=0000, B=0000, add -> R=0000, Co=0; A=0000, B=0001, add -> R=0001, Co=0.
//   - A=1110, B=1100, sub -> R=0010, Co=1; A=1111, B=1111, sub -> R=0000, Co=1.
//   - A=1010, B=0011, add -> R=1101, Co=0; A=1111, B=0001, add -> R=0000, Co=1.
//   - A=0011, B=0101, sub -> R=1110, Co=0 (borrow case).
//   - Exhaustive: all 512 {add_sub,A,B} combinations, one per cycle, checked
//     against the 5-bit reference sum one cycle later, with reset pulsed mid-sweep.

Source files
------------

// File: rtl/addsub4b_if.sv
// Operand/result bundle for addsub4b: operation select, bit-level operands and registered result.
// master drives add_sub, A3..A0, B3..B0 and observes Co, R3..R0; slave is the adder/subtractor.
// No handshake: the slave accepts a new operation every cycle and never stalls.
interface addsub4b_if;
    logic add_sub;
    logic A3, A2, A1, A0;
    logic B3, B2, B1, B0;
    logic Co;
    logic R3, R2, R1, R0;

    modport master (
        output add_sub, A3, A2, A1, A0, B3, B2, B1, B0,
        input  Co, R3, R2, R1, R0
    );

    modport slave (
        input  add_sub, A3, A2, A1, A0, B3, B2, B1, B0,
        output Co, R3, R2, R1, R0
    );
endinterface

// File: rtl/addsub4b.sv
// 4-bit ripple-carry adder/subtractor (add_sub=0: A+B, add_sub=1: A-B) with registered {Co,R}.
// Latency: 1 cycle; inputs sampled at a rising edge appear on Co/R3..R0 right after that edge.
// Backpressure: none; a new operation is accepted every cycle.
// Ports: clk, reset (sync, active-high), bus (slave modport: add_sub, A3..A0, B3..B0 in; Co, R3..R0 out).
module addsub4b (
    input  logic        clk,
    input  logic        reset,
    addsub4b_if.slave   bus
);

    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
    logic       co_q;
    logic [3:0] r_q;

    assign a = {bus.A3, bus.A2, bus.A1, bus.A0};
    assign b = {bus.B3, bus.B2, bus.B1, bus.B0};

    // Chain of four full adders. B is conditionally inverted and the carry-in is
    // the op select itself, so subtract becomes A + ~B + 1 and Co reads as "no borrow".
    function automatic logic [4:0] ripple(input logic [3:0] op_a,
                                          input logic [3:0] op_b,
                                          input logic       sub);
        logic       c;
        logic       bx;
        logic [3:0] s;
        c = sub;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            bx   = op_b[i] ^ sub;
            s[i] = op_a[i] ^ bx ^ c;
            c    = (op_a[i] & bx) | (op_a[i] & c) | (bx & c);
        end
        return {c, s};
    endfunction

    assign sum = ripple(a, b, bus.add_sub);

    always_ff @(posedge clk) begin
        if (reset) begin
            co_q <= 1'b0;
            r_q  <= 4'b0000;
        end else begin
            co_q <= sum[4];
            r_q  <= sum[3:0];
        end
    end

    assign bus.Co = co_q;
    assign bus.R3 = r_q[3];
    assign bus.R2 = r_q[2];
    assign bus.R1 = r_q[1];
    assign bus.R0 = r_q[0];

endmodule

// File: tb/tb_addsub4b.sv
// Self-checking bench for addsub4b: reset, directed boundary cases, exhaustive sweep
// with a mid-sweep reset, and a random tail with add_sub toggling every cycle.
module tb_addsub4b;

    logic clk = 1'b0;
    logic reset;

    addsub4b_if bus ();

    addsub4b dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] prev_exp;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {Co,R}=%05b expected %05b", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Add gives a 5-bit sum; subtract gives the
    // difference mod 16 with Co meaning "A >= B" (no borrow).
    function automatic logic [4:0] ref_model(input logic op, input logic [3:0] a, input logic [3:0] b);
        int         ai;
        int         bi;
        int         t;
        logic [4:0] res;
        ai = int'(a);
        bi = int'(b);
        if (!op) begin
            t   = ai + bi;
            res = t[4:0];
        end else begin
            t      = ai - bi;
            res[3:0] = t[3:0];
            res[4]   = (ai >= bi);
        end
        return res;
    endfunction

    function automatic logic [4:0] obs();
        return {bus.Co, bus.R3, bus.R2, bus.R1, bus.R0};
    endfunction

    task automatic drive(input logic op, input logic [3:0] a, input logic [3:0] b);
        bus.add_sub = op;
        {bus.A3, bus.A2, bus.A1, bus.A0} = a;
        {bus.B3, bus.B2, bus.B1, bus.B0} = b;
    endtask

    // One operation: change inputs at the falling edge, confirm the outputs still hold
    // the previous result, then check the registered result just after the rising edge.
    task automatic op_cycle(input string tag, input logic op, input logic [3:0] a,
                            input logic [3:0] b, input logic [4:0] exp);
        @(negedge clk);
        reset = 1'b0;
        drive(op, a, b);
        #1;
        chk({tag, "_hold"}, obs(), prev_exp);
        @(posedge clk);
        #1;
        chk(tag, obs(), exp);
        prev_exp = exp;
    endtask

    task automatic reset_cycle(input string tag);
        @(negedge clk);
        reset = 1'b1;
        drive(1'($urandom), 4'($urandom), 4'($urandom));
        @(posedge clk);
        #1;
        chk(tag, obs(), 5'b00000);
        prev_exp = 5'b00000;
    endtask

    initial begin
        logic       op;
        logic [3:0] a;
        logic [3:0] b;

        reset = 1'b1;
        drive(1'b1, 4'hF, 4'h3);
        reset_cycle("reset0");
        reset_cycle("reset1");

        // First edge after release registers that cycle's inputs.
        op_cycle("release", 1'b0, 4'b0000, 4'b0000, 5'b0_0000);
        op_cycle("add_0_1",   1'b0, 4'b0000, 4'b0001, 5'b0_0001);
        op_cycle("sub_e_c",   1'b1, 4'b1110, 4'b1100, 5'b1_0010);
        op_cycle("sub_f_f",   1'b1, 4'b1111, 4'b1111, 5'b1_0000);
        op_cycle("add_a_3",   1'b0, 4'b1010, 4'b0011, 5'b0_1101);
        op_cycle("add_f_1",   1'b0, 4'b1111, 4'b0001, 5'b1_0000);
        op_cycle("sub_3_5",   1'b1, 4'b0011, 4'b0101, 5'b0_1110);
        op_cycle("sub_0_0",   1'b1, 4'b0000, 4'b0000, 5'b1_0000);
        op_cycle("add_f_f",   1'b0, 4'b1111, 4'b1111, 5'b1_1110);

        // Exhaustive sweep of {add_sub,A,B}, with reset pulsed halfway through.
        for (int i = 0; i < 512; i++) begin
            if (i == 256) begin
                reset_cycle("reset_mid");
            end
            op = 1'(i >> 8);
            a  = 4'(i >> 4);
            b  = 4'(i);
            op_cycle("sweep", op, a, b, ref_model(op, a, b));
        end

        // Random tail with add_sub toggling every cycle.
        for (int i = 0; i < 64; i++) begin
            op = 1'(i);
            a  = 4'($urandom);
            b  = 4'($urandom);
            op_cycle("rand", op, a, b, ref_model(op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
